// File: rtl/operand_read_pkg.sv
// Shared state encoding, PC flag positions and sign-extension helper
// for the operand read stage.
package operand_read_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    localparam int PC_CTL_W   = 3;
    localparam int PC_SRC_W   = 2;
    localparam int PC_INC_BIT = 0;
    localparam int PC_ADD_BIT = 1;
    localparam int PC_SET_BIT = 2;

    // Widest operand the sign-extension helper supports.
    localparam int SEXT_MAX_W = 64;

    function automatic logic [SEXT_MAX_W-1:0] sign_extend(
        input logic [SEXT_MAX_W-1:0] value,
        input int                    width
    );
        logic [SEXT_MAX_W-1:0] upper_mask;
        logic                  sign;
        upper_mask = {SEXT_MAX_W{1'b1}} << width;
        sign       = |(value & ({{(SEXT_MAX_W-1){1'b0}}, 1'b1} << (width - 1)));
        return sign ? (value | upper_mask) : (value & ~upper_mask);
    endfunction

endpackage

// File: rtl/operand_mux.sv
// Per-channel operand select: immediate, hard zero, register-file data
// or writeback bypass. Purely combinational.
module operand_mux
    import operand_read_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RADDR_W  = 4,
    parameter int IMM_W    = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               i_need,
    input  logic               i_is_imm,
    input  logic [IMM_W-1:0]   i_imm,
    input  logic [RADDR_W-1:0] i_idx,
    input  logic               i_use_rf,
    input  logic [DATA_W-1:0]  i_rf_value,
    input  logic [DATA_W-1:0]  i_cur_value,
    input  logic               i_wb_en,
    input  logic [RADDR_W-1:0] i_wb_reg,
    input  logic [DATA_W-1:0]  i_wb_value,
    output logic [DATA_W-1:0]  o_value
);

    logic              w_is_zero_reg;
    logic              w_bypass;
    logic [DATA_W-1:0] w_imm_ext;

    assign w_is_zero_reg = ZERO_REG && (i_idx == '0);
    assign w_bypass      = i_wb_en && (i_wb_reg == i_idx);
    assign w_imm_ext     = DATA_W'(sign_extend(SEXT_MAX_W'(i_imm), IMM_W));

    // Zero register wins over bypass so index 0 can never be overwritten.
    always_comb begin
        // NOTE: assign a default first so every path drives o_value and no latch is inferred.
        o_value = '0;
        if (!i_need) begin
            o_value = '0;
        end else if (i_is_imm) begin
            o_value = w_imm_ext;
        end else if (w_is_zero_reg) begin
            o_value = '0;
        end else if (w_bypass) begin
            o_value = i_wb_value;
        end else if (i_use_rf) begin
            o_value = i_rf_value;
        end else begin
            o_value = i_cur_value;
        end
    end

endmodule

// File: rtl/operand_read.sv
// Operand read stage: accepts a decoded instruction, reads up to two
// register operands, applies writeback bypass and holds results for execute.
module operand_read
    import operand_read_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int RADDR_W  = 4,
    parameter int IMM_W    = 5,
    parameter int PC_W     = 31,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                read_a,
    input  logic                imm_a,
    input  logic [IMM_W-1:0]    arg_a,
    input  logic                read_b,
    input  logic [RADDR_W-1:0]  arg_b,
    input  logic [PC_CTL_W-1:0] pc_ctl,
    input  logic [PC_SRC_W-1:0] pc_src,
    input  logic [PC_W-1:0]     in_pc,
    input  logic                flush,
    output logic                reg_a_read,
    output logic                reg_b_read,
    output logic [RADDR_W-1:0]  reg_a,
    output logic [RADDR_W-1:0]  reg_b,
    input  logic [DATA_W-1:0]   reg_a_value,
    input  logic [DATA_W-1:0]   reg_b_value,
    input  logic                wb_en,
    input  logic [RADDR_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0]   wb_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                src_a_en,
    output logic                src_b_en,
    output logic [DATA_W-1:0]   src_a,
    output logic [DATA_W-1:0]   src_b,
    output logic [PC_CTL_W-1:0] o_pc_ctl,
    output logic [PC_SRC_W-1:0] o_pc_src,
    output logic [PC_W-1:0]     pc
);

    state_t r_state;
    state_t w_state_nxt;

    logic                r_read_a;
    logic                r_imm_a;
    logic [IMM_W-1:0]    r_arg_a;
    logic                r_read_b;
    logic [RADDR_W-1:0]  r_arg_b;
    logic [PC_CTL_W-1:0] r_pc_ctl;
    logic [PC_SRC_W-1:0] r_pc_src;
    logic [PC_W-1:0]     r_pc;

    logic                r_src_a_en;
    logic                r_src_b_en;
    logic [DATA_W-1:0]   r_src_a;
    logic [DATA_W-1:0]   r_src_b;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_in_read;
    logic                w_capture;
    logic [RADDR_W-1:0]  w_idx_a_in;
    logic [RADDR_W-1:0]  w_idx_a_lat;
    logic                w_strobe_a;
    logic                w_strobe_b;
    logic [DATA_W-1:0]   w_mux_a;
    logic [DATA_W-1:0]   w_mux_b;

    // Only the low RADDR_W bits of arg_a select a register.
    generate
        if (IMM_W >= RADDR_W) begin : g_idx_slice
            assign w_idx_a_in  = arg_a[RADDR_W-1:0];
            assign w_idx_a_lat = r_arg_a[RADDR_W-1:0];
        end else begin : g_idx_pad
            assign w_idx_a_in  = RADDR_W'(arg_a);
            assign w_idx_a_lat = RADDR_W'(r_arg_a);
        end
    endgenerate

    assign w_in_ready = !flush && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
    assign w_accept   = w_in_ready && in_valid;
    assign w_in_read  = (r_state == ST_READ);
    assign w_capture  = !flush && (w_in_read || ((r_state == ST_HOLD) && !out_ready));

    assign w_strobe_a = w_accept && read_a && !imm_a && !(ZERO_REG && (w_idx_a_in == '0));
    assign w_strobe_b = w_accept && read_b && !(ZERO_REG && (arg_b == '0));

    assign in_ready   = w_in_ready;
    assign reg_a_read = w_strobe_a;
    assign reg_b_read = w_strobe_b;
    assign reg_a      = w_strobe_a ? w_idx_a_in : '0;
    assign reg_b      = w_strobe_b ? arg_b : '0;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) w_state_nxt = ST_READ;
                ST_READ: w_state_nxt = ST_HOLD;
                ST_HOLD: if (out_ready) w_state_nxt = in_valid ? ST_READ : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!cpu_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction fields are latched at acceptance and drive the muxes in READ/HOLD.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_read_a <= 1'b0;
            r_imm_a  <= 1'b0;
            r_arg_a  <= '0;
            r_read_b <= 1'b0;
            r_arg_b  <= '0;
            r_pc_ctl <= '0;
            r_pc_src <= '0;
            r_pc     <= '0;
        end else if (w_accept) begin
            r_read_a             <= read_a;
            r_imm_a              <= imm_a;
            r_arg_a              <= arg_a;
            r_read_b             <= read_b;
            r_arg_b              <= arg_b;
            r_pc_ctl[PC_INC_BIT] <= pc_ctl[PC_INC_BIT];
            r_pc_ctl[PC_ADD_BIT] <= pc_ctl[PC_ADD_BIT];
            r_pc_ctl[PC_SET_BIT] <= pc_ctl[PC_SET_BIT];
            r_pc_src             <= pc_src;
            r_pc                 <= in_pc;
        end
    end

    operand_mux #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .IMM_W    (IMM_W),
        .ZERO_REG (ZERO_REG)
    ) u_mux_a (
        .i_need      (r_read_a),
        .i_is_imm    (r_imm_a),
        .i_imm       (r_arg_a),
        .i_idx       (w_idx_a_lat),
        .i_use_rf    (w_in_read),
        .i_rf_value  (reg_a_value),
        .i_cur_value (r_src_a),
        .i_wb_en     (wb_en),
        .i_wb_reg    (wb_reg),
        .i_wb_value  (wb_value),
        .o_value     (w_mux_a)
    );

    operand_mux #(
        .DATA_W   (DATA_W),
        .RADDR_W  (RADDR_W),
        .IMM_W    (IMM_W),
        .ZERO_REG (ZERO_REG)
    ) u_mux_b (
        .i_need      (r_read_b),
        .i_is_imm    (1'b0),
        .i_imm       ('0),
        .i_idx       (r_arg_b),
        .i_use_rf    (w_in_read),
        .i_rf_value  (reg_b_value),
        .i_cur_value (r_src_b),
        .i_wb_en     (wb_en),
        .i_wb_reg    (wb_reg),
        .i_wb_value  (wb_value),
        .o_value     (w_mux_b)
    );

    // Operands are captured in READ and refreshed by bypass while stalled in HOLD.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_src_a_en <= 1'b0;
            r_src_b_en <= 1'b0;
            r_src_a    <= '0;
            r_src_b    <= '0;
        end else if (w_capture) begin
            r_src_a_en <= r_read_a;
            r_src_b_en <= r_read_b;
            r_src_a    <= w_mux_a;
            r_src_b    <= w_mux_b;
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign src_a_en  = r_src_a_en;
    assign src_b_en  = r_src_b_en;
    assign src_a     = r_src_a;
    assign src_b     = r_src_b;
    assign o_pc_ctl  = r_pc_ctl;
    assign o_pc_src  = r_pc_src;
    assign pc        = r_pc;

endmodule

// File: tb/tb_operand_read.sv
// Self-checking bench for operand_read: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_operand_read;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 4;
    localparam int IMM_W   = 5;
    localparam int PC_W    = 31;

    logic               cpu_clk = 1'b0;
    logic               cpu_rst = 1'b0;
    logic               in_valid, in_ready;
    logic               read_a, imm_a, read_b;
    logic [IMM_W-1:0]   arg_a;
    logic [RADDR_W-1:0] arg_b;
    logic [2:0]         pc_ctl, o_pc_ctl;
    logic [1:0]         pc_src, o_pc_src;
    logic [PC_W-1:0]    in_pc, pc;
    logic               flush;
    logic               reg_a_read, reg_b_read;
    logic [RADDR_W-1:0] reg_a, reg_b;
    logic [DATA_W-1:0]  reg_a_value = '0, reg_b_value = '0;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]  wb_value;
    logic               out_valid, out_ready;
    logic               src_a_en, src_b_en;
    logic [DATA_W-1:0]  src_a, src_b;

    logic [DATA_W-1:0]  rf [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    operand_read #(
        .DATA_W (DATA_W), .RADDR_W (RADDR_W), .IMM_W (IMM_W), .PC_W (PC_W), .ZERO_REG (1'b1)
    ) dut (
        .cpu_clk (cpu_clk), .cpu_rst (cpu_rst),
        .in_valid (in_valid), .in_ready (in_ready),
        .read_a (read_a), .imm_a (imm_a), .arg_a (arg_a),
        .read_b (read_b), .arg_b (arg_b),
        .pc_ctl (pc_ctl), .pc_src (pc_src), .in_pc (in_pc), .flush (flush),
        .reg_a_read (reg_a_read), .reg_b_read (reg_b_read),
        .reg_a (reg_a), .reg_b (reg_b),
        .reg_a_value (reg_a_value), .reg_b_value (reg_b_value),
        .wb_en (wb_en), .wb_reg (wb_reg), .wb_value (wb_value),
        .out_valid (out_valid), .out_ready (out_ready),
        .src_a_en (src_a_en), .src_b_en (src_b_en),
        .src_a (src_a), .src_b (src_b),
        .o_pc_ctl (o_pc_ctl), .o_pc_src (o_pc_src), .pc (pc)
    );

    // Register file returns data one cycle after a strobe, junk otherwise.
    always @(posedge cpu_clk) begin
        reg_a_value <= reg_a_read ? rf[reg_a] : DATA_W'($urandom);
        reg_b_value <= reg_b_read ? rf[reg_b] : DATA_W'($urandom);
    end

    typedef struct {
        logic        read_a;
        logic        imm_a;
        logic [4:0]  arg_a;
        logic        read_b;
        logic [3:0]  arg_b;
        logic [2:0]  ctl;
        logic [1:0]  src;
        logic [30:0] pcv;
        logic        exp_rd_a;
        logic        exp_rd_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_instr(input logic ra, input logic ia, input logic [4:0] aa,
                             input logic rb, input logic [3:0] ab);
        read_a = ra;
        imm_a  = ia;
        arg_a  = aa;
        read_b = rb;
        arg_b  = ab;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        next_cycle();
        set_instr(v.read_a, v.imm_a, v.arg_a, v.read_b, v.arg_b);
        pc_ctl = v.ctl; pc_src = v.src; in_pc = v.pcv;
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check($sformatf("v%0d in_ready", k), in_ready, 1);
        check($sformatf("v%0d reg_a_read", k), reg_a_read, v.exp_rd_a);
        check($sformatf("v%0d reg_b_read", k), reg_b_read, v.exp_rd_b);
        if (v.exp_rd_a) check($sformatf("v%0d reg_a", k), reg_a, v.arg_a[3:0]);
        if (v.exp_rd_b) check($sformatf("v%0d reg_b", k), reg_b, v.arg_b);
        next_cycle();
        in_valid = 1'b0;
        #1;
        check($sformatf("v%0d read out_valid", k), out_valid, 0);
        check($sformatf("v%0d read in_ready", k), in_ready, 0);
        next_cycle();
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d out_valid", k), out_valid, 1);
        check($sformatf("v%0d src_a_en", k), src_a_en, v.read_a);
        check($sformatf("v%0d src_a", k), src_a, v.exp_a);
        check($sformatf("v%0d src_b_en", k), src_b_en, v.read_b);
        check($sformatf("v%0d src_b", k), src_b, v.exp_b);
        check($sformatf("v%0d pc", k), pc, v.pcv);
        check($sformatf("v%0d pc_ctl", k), o_pc_ctl, v.ctl);
        check($sformatf("v%0d pc_src", k), o_pc_src, v.src);
        next_cycle();
        out_ready = 1'b0;
        #1;
        check($sformatf("v%0d done out_valid", k), out_valid, 0);
    endtask

    // Transaction model: one in-flight instruction, expected values updated by writebacks.
    task automatic run_random(input int cycles);
        logic        live, exp_valid, hs, exp_ready, acc, exp_sa, exp_sb;
        logic        a_en, b_en, a_byp, b_byp;
        logic [3:0]  a_idx, b_idx;
        logic [15:0] ea, eb;
        logic [30:0] epc;
        logic [2:0]  ectl;
        logic [1:0]  esrc;
        int          acc_cyc;
        live = 1'b0; acc_cyc = 0; a_en = 0; b_en = 0; a_byp = 0; b_byp = 0;
        a_idx = '0; b_idx = '0; ea = '0; eb = '0; epc = '0; ectl = '0; esrc = '0;
        for (int c = 0; c < cycles; c++) begin
            next_cycle();
            in_valid  = ($urandom_range(0, 3) != 0);
            read_a    = ($urandom_range(0, 3) != 0);
            imm_a     = ($urandom_range(0, 3) == 0);
            arg_a     = {1'($urandom), 4'($urandom_range(0, 7))};
            read_b    = ($urandom_range(0, 3) != 0);
            arg_b     = 4'($urandom_range(0, 7));
            pc_ctl    = 3'($urandom);
            pc_src    = 2'($urandom);
            in_pc     = 31'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_reg    = 4'($urandom_range(0, 7));
            wb_value  = 16'($urandom);
            #1;
            exp_valid = live && (c >= acc_cyc + 2);
            check("rnd out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("rnd src_a_en", src_a_en, a_en);
                check("rnd src_a", src_a, ea);
                check("rnd src_b_en", src_b_en, b_en);
                check("rnd src_b", src_b, eb);
                check("rnd pc", pc, epc);
                check("rnd pc_ctl", o_pc_ctl, ectl);
                check("rnd pc_src", o_pc_src, esrc);
            end
            hs        = exp_valid && out_ready;
            exp_ready = !live || hs;
            check("rnd in_ready", in_ready, exp_ready);
            acc    = in_valid && exp_ready;
            exp_sa = acc && read_a && !imm_a && (arg_a[3:0] != 4'd0);
            exp_sb = acc && read_b && (arg_b != 4'd0);
            check("rnd reg_a_read", reg_a_read, exp_sa);
            check("rnd reg_b_read", reg_b_read, exp_sb);
            if (exp_sa) check("rnd reg_a", reg_a, arg_a[3:0]);
            if (exp_sb) check("rnd reg_b", reg_b, arg_b);
            if (hs) live = 1'b0;
            if (live && wb_en) begin
                if (a_byp && wb_reg == a_idx) ea = wb_value;
                if (b_byp && wb_reg == b_idx) eb = wb_value;
            end
            if (acc) begin
                live    = 1'b1;
                acc_cyc = c;
                a_en    = read_a;
                b_en    = read_b;
                a_idx   = arg_a[3:0];
                b_idx   = arg_b;
                a_byp   = read_a && !imm_a && (a_idx != 4'd0);
                b_byp   = read_b && (b_idx != 4'd0);
                ea      = !read_a ? 16'h0 : imm_a ? {{11{arg_a[4]}}, arg_a} : a_byp ? rf[a_idx] : 16'h0;
                eb      = b_byp ? rf[b_idx] : 16'h0;
                epc     = in_pc;
                ectl    = pc_ctl;
                esrc    = pc_src;
            end
        end
        next_cycle();
        in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        repeat (3) next_cycle();
        out_ready = 1'b0;
    endtask

    logic [4:0]  b2b_idx [4];
    logic [15:0] b2b_exp [4];
    int          nacc, nhs;

    initial begin
        in_valid = 0; read_a = 0; imm_a = 0; arg_a = '0; read_b = 0; arg_b = '0;
        pc_ctl = '0; pc_src = '0; in_pc = '0; flush = 0;
        wb_en = 0; wb_reg = '0; wb_value = '0; out_ready = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'(16'h1111 * i);
        rf[0] = 16'hBAD0;
        rf[3] = 16'h1234;
        rf[5] = 16'h00FF;

        vecs[0] = '{1'b1, 1'b0, 5'd3,      1'b1, 4'd5,  3'b001, 2'b01, 31'h0000_1000, 1'b1, 1'b1, 16'h1234, 16'h00FF};
        vecs[1] = '{1'b1, 1'b1, 5'b10110,  1'b0, 4'd5,  3'b100, 2'b10, 31'h7FFF_FFFF, 1'b0, 1'b0, 16'hFFF6, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 5'b01111,  1'b1, 4'd0,  3'b010, 2'b11, 31'h1234_5678, 1'b0, 1'b0, 16'h000F, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 5'd0,      1'b1, 4'd15, 3'b111, 2'b00, 31'h4000_0001, 1'b0, 1'b1, 16'h0000, 16'hFFFF};
        vecs[4] = '{1'b1, 1'b0, 5'b10011,  1'b1, 4'd7,  3'b000, 2'b01, 31'h2AAA_AAAA, 1'b1, 1'b1, 16'h1234, 16'h7777};
        vecs[5] = '{1'b0, 1'b0, 5'd3,      1'b0, 4'd5,  3'b011, 2'b10, 31'h0000_0000, 1'b0, 1'b0, 16'h0000, 16'h0000};

        repeat (2) @(posedge cpu_clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset src_a", src_a, 0);
        check("reset src_b", src_b, 0);
        check("reset src_en", {src_a_en, src_b_en}, 0);
        check("reset pc", pc, 0);
        check("reset pc_ctl/src", {o_pc_ctl, o_pc_src}, 0);
        check("reset strobes", {reg_a_read, reg_b_read}, 0);
        cpu_rst = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Stall with a bypass hit on A in the second stall cycle.
        next_cycle();
        set_instr(1, 0, 5'd3, 1, 4'd5); in_valid = 1; out_ready = 0;
        next_cycle(); in_valid = 0;
        next_cycle(); #1;
        check("stall1 out_valid", out_valid, 1);
        check("stall1 src_a", src_a, 16'h1234);
        next_cycle();
        wb_en = 1; wb_reg = 4'd3; wb_value = 16'hBEEF;
        #1;
        check("stall2 src_a", src_a, 16'h1234);
        next_cycle(); wb_en = 0; #1;
        check("stall3 out_valid", out_valid, 1);
        check("stall3 src_a", src_a, 16'hBEEF);
        check("stall3 src_b", src_b, 16'h00FF);
        next_cycle(); out_ready = 1; #1;
        check("stall end src_a", src_a, 16'hBEEF);
        next_cycle(); out_ready = 0;

        // Zero register is never bypassed; same writeback may hit both operands.
        set_instr(1, 0, 5'd0, 1, 4'd6); in_valid = 1;
        next_cycle(); in_valid = 0; wb_en = 1; wb_reg = 4'd0; wb_value = 16'h7777;
        next_cycle(); wb_en = 0; #1;
        check("zbyp src_a", src_a, 16'h0000);
        check("zbyp src_b", src_b, 16'h6666);
        out_ready = 1;
        next_cycle(); out_ready = 0;
        set_instr(1, 0, 5'd6, 1, 4'd6); in_valid = 1;
        next_cycle(); in_valid = 0; wb_en = 1; wb_reg = 4'd6; wb_value = 16'h5A5A;
        next_cycle(); wb_en = 0; out_ready = 1; #1;
        check("dual byp src_a", src_a, 16'h5A5A);
        check("dual byp src_b", src_b, 16'h5A5A);
        next_cycle(); out_ready = 0;

        // Back-to-back: one instruction leaves every two cycles.
        b2b_idx = '{5'd0, 5'd7, 5'd0, 5'd9};
        b2b_exp = '{16'h0000, 16'h7777, 16'h0000, 16'h9999};
        nacc = 0; nhs = 0; out_ready = 1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            in_valid = (nacc < 4);
            if (nacc < 4) set_instr(1, 0, b2b_idx[nacc], 0, 4'd0);
            #1;
            check($sformatf("b2b c%0d in_ready", c), in_ready, (c % 2 == 0) || (c >= 8));
            check($sformatf("b2b c%0d out_valid", c), out_valid, (c >= 2) && (c % 2 == 0));
            if (out_valid && nhs < 4) begin
                check($sformatf("b2b hs%0d src_a", nhs), src_a, b2b_exp[nhs]);
                nhs++;
            end
            if (in_valid && in_ready) begin
                check($sformatf("b2b acc%0d strobe", nacc), reg_a_read, b2b_idx[nacc] != 5'd0);
                nacc++;
            end
        end
        check("b2b handshakes", nhs, 4);
        in_valid = 0; out_ready = 0;

        // Flush in READ: instruction dies, next one accepted the cycle after.
        next_cycle();
        set_instr(1, 0, 5'd3, 1, 4'd5); in_valid = 1;
        next_cycle();
        flush = 1; out_ready = 1; set_instr(1, 0, 5'd6, 1, 4'd7);
        #1;
        check("flush in_ready", in_ready, 0);
        check("flush strobes", {reg_a_read, reg_b_read}, 0);
        next_cycle(); flush = 0; #1;
        check("post flush out_valid", out_valid, 0);
        check("post flush in_ready", in_ready, 1);
        check("post flush reg_a_read", reg_a_read, 1);
        check("post flush reg_a", reg_a, 4'd6);
        next_cycle(); in_valid = 0; #1;
        check("post flush read out_valid", out_valid, 0);
        next_cycle(); #1;
        check("post flush out_valid", out_valid, 1);
        check("post flush src_a", src_a, 16'h6666);
        check("post flush src_b", src_b, 16'h7777);

        // Flush in HOLD together with out_ready: no new acceptance.
        next_cycle(); out_ready = 0;
        set_instr(0, 1, 5'd1, 0, 4'd0); in_valid = 1;
        next_cycle(); in_valid = 0;
        next_cycle(); flush = 1; out_ready = 1; in_valid = 1; #1;
        check("hold flush out_valid", out_valid, 1);
        check("hold flush in_ready", in_ready, 0);
        next_cycle(); flush = 0; in_valid = 0; #1;
        check("hold flush after out_valid", out_valid, 0);
        check("hold flush after in_ready", in_ready, 1);
        out_ready = 0;

        // Reset mid-HOLD.
        next_cycle();
        set_instr(1, 0, 5'd3, 1, 4'd5); in_pc = 31'h55; pc_ctl = 3'b101; pc_src = 2'b11; in_valid = 1;
        next_cycle(); in_valid = 0;
        next_cycle(); #1;
        check("rst pre out_valid", out_valid, 1);
        cpu_rst = 1'b0;
        #1;
        check("rst mid out_valid", out_valid, 0);
        check("rst mid in_ready", in_ready, 1);
        check("rst mid src_a", src_a, 0);
        check("rst mid src_b", src_b, 0);
        check("rst mid src_en", {src_a_en, src_b_en}, 0);
        check("rst mid pc", pc, 0);
        next_cycle(); cpu_rst = 1'b1;

        run_random(600);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_read.md
Name: operand_read

Overview:
- Parametrised successor of the operand read stage. Accepts one decoded instruction per handshake and issues register-file reads for up to two operands (A, B).
- Builds operand values from register data, a sign-extended immediate or zero. Applies a writeback bypass and presents registered operands and PC controls to execute over a valid/ready handshake.
- Sits between decode and execute. Supports stall (back-pressure) and flush.

Parameters:
- DATA_W, 16, operand and register width.
- RADDR_W, 4, register index width.
- IMM_W, 5, immediate field width on channel A; sign-extended to DATA_W.
- PC_W, 31, program counter width.
- ZERO_REG, 1, when 1 register index 0 reads as 0 and issues no port read.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- read_a  in  1  operand A needed.
- imm_a  in  1  A is an immediate, not a register.
- arg_a  in  IMM_W  A register index (low RADDR_W bits) or immediate.
- read_b  in  1  operand B needed.
- arg_b  in  RADDR_W  B register index.
- pc_ctl  in  3  {set, add, inc} flags, passed through.
- pc_src  in  2  PC source select, passed through.
- in_pc  in  PC_W  instruction PC.
- flush  in  1  kill in-flight and held instruction.
- reg_a_read / reg_b_read  out  1  register-file read strobes.
- reg_a / reg_b  out  RADDR_W  read indices.
- reg_a_value / reg_b_value  in  DATA_W  read data; valid exactly 1 cycle after strobe.
- wb_en  in  1  writeback this cycle.
- wb_reg  in  RADDR_W  writeback index.
- wb_value  in  DATA_W  writeback data.
- out_valid  out  1  operands valid.
- out_ready  in  1  execute accepts.
- src_a_en / src_b_en  out  1  operand present.
- src_a / src_b  out  DATA_W  operand values.
- o_pc_ctl  out  3  registered PC flags.
- o_pc_src  out  2  registered PC source.
- pc  out  PC_W  registered PC.

Behaviour:
- Reset (cpu_rst low, asynchronous):
  - State is IDLE.
  - All outputs are 0, except in_ready, which is 1.
- States and transitions:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch fields and drive read strobes combinationally in the same cycle. A strobe fires only for an operand that is needed, is a register, and (when ZERO_REG=1) has a nonzero index.
    - Go to READ.
  - READ (1 cycle):
    - in_ready=0.
    - Capture reg_*_value into the operand registers.
    - Go to HOLD.
  - HOLD:
    - out_valid=1; outputs are stable until out_ready.
    - in_ready=out_ready.
    - out_ready with in_valid: accept the next instruction in the same cycle (strobes issued) and go to READ. Throughput is one instruction per 2 cycles.
    - out_ready without in_valid: go to IDLE.
- Latency: acceptance at cycle N gives out_valid at cycle N+2.
- Operand value rules:
  - imm_a=1: src_a = sign-extend(arg_a), with no read strobe.
  - Operand not needed: src_x_en=0 and src_x=0.
  - ZERO_REG=1 and index 0: value 0.
- Bypass:
  - In READ and in every HOLD cycle, each enabled register operand with wb_en and wb_reg equal to its index takes wb_value. In READ this overrides reg_*_value.
  - Index 0 is never bypassed when ZERO_REG=1.
  - A and B may both match the same writeback.
- flush:
  - Has highest priority and goes to IDLE next cycle.
  - out_valid drops the next cycle; in_valid in the flush cycle is ignored (in_ready=0 while flush).
  - Strobes already issued are harmless; the returned data is discarded.
- Simultaneous events:
  - out_ready together with flush: the held instruction counts as consumed (the handshake completed in that cycle); no new acceptance.
- Widths:
  - PC, pc_ctl and pc_src pass through unchanged.
  - When IMM_W > RADDR_W, arg_a's upper bits are ignored for register reads.

Decomposition:
- Package operand_read_pkg:
  - State enum (IDLE, READ, HOLD).
  - PC control flag bit positions.
  - Sign-extension function parametrised on IMM_W/DATA_W.
- One sub-module, operand_mux: combinational per-channel select (imm / zero / regfile / bypass). Instantiated twice (A, B).

Test Plan:
- Reset mid-HOLD → out_valid=0 immediately, in_ready=1, all operand outputs 0.
- Register A (r3, reads 0x1234) + register B (r5, reads 0x00FF) → strobes reg_a=3, reg_b=5 in the accept cycle; 2 cycles later out_valid, src_a=0x1234, src_b=0x00FF.
- imm_a=1, arg_a=5'b10110 → src_a=0xFFF6, reg_a_read never asserted.
- Stall: out_ready=0 for 3 cycles with wb_en, wb_reg=3, wb_value=0xBEEF in the second stall cycle → src_a becomes 0xBEEF; src_b unchanged.
- Back-to-back: out_ready=1, in_valid held → an instruction leaves every 2 cycles; r0 operand → 0 with no strobe.
- flush in READ with out_ready=1 → no out_valid for that instruction; next in_valid is accepted the cycle after.
